// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction memory port, decoder/ALU feedback,
// start control, branch-target LUT write port and status outputs.
interface fetch_sequencer_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
);
  logic               start;
  logic [PC_W-1:0]    start_addr;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               branch_in;
  logic [1:0]         how_high_in;
  logic               cond_in;
  logic               stall;
  logic               lut_we;
  logic [1:0]         lut_idx;
  logic [PC_W-1:0]    lut_data;
  logic [PC_W-1:0]    pc;
  logic [15:0]        icount;
  logic               done;

  modport master (
    input  start, start_addr, imem_data, branch_in, how_high_in, cond_in,
           stall, lut_we, lut_idx, lut_data,
    output imem_addr, instr_out, instr_valid, pc, icount, done
  );

  modport slave (
    output start, start_addr, imem_data, branch_in, how_high_in, cond_in,
           stall, lut_we, lut_idx, lut_data,
    input  imem_addr, instr_out, instr_valid, pc, icount, done
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing unit: owns the PC, fetches from a synchronous
// instruction memory and redirects through a 4-entry branch-target LUT.
module fetch_sequencer #(
  parameter int               PC_W    = 10,
  parameter int               INSTR_W = 9,
  parameter int               OP_W    = 3,
  parameter logic [OP_W-1:0]  HALT_OP = 3'b111
) (
  input  logic              Clk,
  input  logic              Reset_n,
  fetch_sequencer_if.master bus
);

  // state  | meaning
  // S_IDLE | waiting for start after reset
  // S_REQ  | imem_addr = pc presented to memory
  // S_LOAD | memory data valid, captured into ir
  // S_EXEC | ir presented to decoder, instr_valid high
  // S_DONE | halt opcode retired, waiting for restart
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_LOAD = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [15:0]        icount_q, icount_d;
  logic [PC_W-1:0]    lut_q [4];
  logic [OP_W-1:0]    opcode;

  assign opcode = ir_q[INSTR_W-1 -: OP_W];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    icount_d = icount_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          pc_d     = bus.start_addr;
          icount_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ:  state_d = S_LOAD;
      S_LOAD: begin
        ir_d    = bus.imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!bus.stall) begin
          if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
          if (opcode == HALT_OP) begin
            state_d = S_DONE;
          end else begin
            // LUT read sees the registered value, so a same-cycle write is not yet visible
            if (bus.branch_in && bus.cond_in) pc_d = lut_q[bus.how_high_in];
            else                              pc_d = pc_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) lut_q[i] <= '0;
    end else if (bus.lut_we) begin
      lut_q[bus.lut_idx] <= bus.lut_data;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = ir_q;
  assign bus.instr_valid = (state_q == S_EXEC);
  assign bus.done        = (state_q == S_DONE);
  assign bus.pc          = pc_q;
  assign bus.icount      = icount_q;

endmodule
